tick_counter_display: RTL and testbench
=======================================

Name: tick_counter_display

Overview:
- Parametrised successor to the board-level divided-clock demo.
- Replaces derived clocks with a single-clock prescaler tick enable.
- Adds a debounced step key and a mode-selectable up/down/step/load counter.
- Drives NUM_DIGITS seven-segment digits showing the counter in hex; sits directly under the DE2 board top, fed by CLOCK_50, KEY and SW.

Parameters:
- DIV, 50000000: prescaler period in CLOCK_50 cycles, ≥2.
- DIV_WIDTH, 26: prescaler register width; must satisfy 2^DIV_WIDTH ≥ DIV.
- DEB_CYCLES, 500000: consecutive stable cycles required to accept a key level change, ≥1.
- DEB_WIDTH, 20: debounce counter width.
- NUM_DIGITS, 4: digit count, 1..8. Counter width CW = 4*NUM_DIGITS (derived, not overridable).

Ports:
- CLOCK_50  in  1  sole clock.
- RESET  in  1  synchronous, active-high reset.
- KEY_N  in  1  raw step key, active-low, asynchronous to CLOCK_50.
- ENABLE  in  1  counter update enable.
- MODE  in  2  00 count up on tick; 01 count down on tick; 10 count up on key press; 11 load.
- LOAD_VAL  in  CW  value loaded in mode 11.
- COUNT  out  CW  current counter value.
- HEX  out  7*NUM_DIGITS  active-low segments; digit i at [7i+6:7i], bit 0 = segment a … bit 6 = segment g; digit i shows COUNT[4i+3:4i].
- TICK  out  1  one-cycle prescaler pulse.
- BLINK  out  1  toggles on every TICK.
- WRAP  out  1  one-cycle pulse on counter wrap-around.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge CLOCK_50 only; no logic clocked by derived signals.
  - RESET has priority over every other input.
  - Reset values: prescaler 0; COUNT 0; TICK 0; BLINK 0; WRAP 0; both sync flops 1; debounced level 1 (released); debounce counter 0; every HEX digit 7'b1000000 ("0").
- Prescaler:
  - Counts 0..DIV-1.
  - On the edge where it equals DIV-1: reload 0, TICK<=1, BLINK toggles. TICK<=0 otherwise.
  - First TICK is high after the DIV-th edge following reset release; period is exactly DIV cycles.
  - Runs regardless of ENABLE and MODE.
- Key path:
  - Two-flop synchroniser KEY_N -> s2.
  - If s2 != level: debounce counter increments; when it equals DEB_CYCLES-1 and s2 still differs, level<=s2 and counter<=0.
  - If s2 == level: counter<=0, so any bounce restarts the count.
  - A press event is the edge where level goes 1->0.
  - A steady low KEY_N produces exactly one press event, on the (2+DEB_CYCLES)-th edge after it goes low. Release produces no event.
- Counter update, evaluated on each edge when ENABLE=1 and not in reset:
  - MODE 00: on a tick edge, COUNT+1 mod 2^CW.
  - MODE 01: on a tick edge, COUNT-1 mod 2^CW.
  - MODE 10: on a press-event edge, COUNT+1. Ticks are ignored.
  - MODE 11: COUNT<=LOAD_VAL every cycle. No WRAP.
  - Key press events in modes 00/01/11 are discarded, but the debouncer keeps tracking.
  - ENABLE=0 holds COUNT; prescaler and debouncer continue.
  - New COUNT is visible in the same cycle TICK is high.
  - MODE/ENABLE changes take effect on the next edge; no partial state is carried over.
- WRAP:
  - <=1 for one cycle on the same edge COUNT steps all-ones->0 (up) or 0->all-ones (down); else 0.
- Display:
  - HEX is registered from COUNT; it lags COUNT by exactly one cycle.
  - Decode covers the full hex range 0-F (A,b,C,d,E,F glyphs), active-low.
- Reset mid-operation:
  - A reset asserted during a pending debounce or mid-prescaler period discards that state.
  - No press event or TICK is generated by the reset itself.

Test Plan (DIV=4, DEB_CYCLES=3, NUM_DIGITS=2, CW=8):
- Reset then MODE=00, ENABLE=1 for 20 cycles -> TICK on edges 4,8,12,16,20; COUNT 1..5; BLINK 1,0,1,0,1; HEX digit0 = "5" (7'b0010010) one cycle after COUNT=5.
- MODE=11, LOAD_VAL=8'hFE, then MODE=00 -> COUNT FF after the next tick, then 00 with WRAP=1 for one cycle; HEX shows "FF" then "00".
- MODE=01 from COUNT=0 -> next tick gives COUNT=FF, WRAP=1; following tick gives FE, WRAP=0.
- MODE=10, KEY_N bounces 0,1,0,1 single cycles then held low 10 cycles -> exactly one increment, occurring 5 edges after the final fall; release gives no change; TICKs do not change COUNT.
- ENABLE=0 across 3 ticks in MODE=00 -> COUNT constant while TICK/BLINK keep toggling; KEY press in MODE=00 -> no change.
- RESET asserted for 1 cycle mid-count (COUNT=8'h37) and during a pending debounce -> next cycle COUNT=0, HEX=7'b1000000 on both digits, TICK/WRAP/BLINK=0, and no press event.

Source files
------------

// File: rtl/tick_counter_display.sv
// Single-clock tick/step counter with debounced key and registered hex display.
// Prescaler tick, two-flop key synchroniser, debouncer and mode-selected counter.
module tick_counter_display #(
  parameter int DIV        = 50000000,
  parameter int DIV_WIDTH  = 26,
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_WIDTH  = 20,
  parameter int NUM_DIGITS = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic                      KEY_N,
  input  logic                      ENABLE,
  input  logic [1:0]                MODE,
  input  logic [4*NUM_DIGITS-1:0]   LOAD_VAL,
  output logic [4*NUM_DIGITS-1:0]   COUNT,
  output logic [7*NUM_DIGITS-1:0]   HEX,
  output logic                      TICK,
  output logic                      BLINK,
  output logic                      WRAP
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int HW = 7 * NUM_DIGITS;

  localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(DIV - 1);
  localparam logic [DIV_WIDTH-1:0] PRESC_ONE  = DIV_WIDTH'(1);
  localparam logic [DEB_WIDTH-1:0] DEB_LAST   = DEB_WIDTH'(DEB_CYCLES - 1);
  localparam logic [DEB_WIDTH-1:0] DEB_ONE    = DEB_WIDTH'(1);
  localparam logic [CW-1:0]        CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]        CNT_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0]        CNT_ZERO   = {CW{1'b0}};
  localparam logic [HW-1:0]        HEX_RESET  = {NUM_DIGITS{7'b1000000}};

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_KEY  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic                 tick_q, tick_d;
  logic                 blink_q, blink_d;
  logic                 s1_q, s1_d;
  logic                 s2_q, s2_d;
  logic                 level_q, level_d;
  logic [DEB_WIDTH-1:0] deb_q, deb_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 wrap_q, wrap_d;
  logic [HW-1:0]        hex_q, hex_d;
  logic                 tick_now;
  logic                 press_now;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    tick_now = (presc_q == PRESC_LAST);
    presc_d  = presc_q + PRESC_ONE;
    tick_d   = 1'b0;
    blink_d  = blink_q;
    if (tick_now) begin
      presc_d = '0;
      tick_d  = 1'b1;
      blink_d = ~blink_q;
    end

    s1_d      = KEY_N;
    s2_d      = s1_q;
    level_d   = level_q;
    deb_d     = '0;
    press_now = 1'b0;
    // Any return of s2 to the accepted level clears the run of differing samples.
    if (s2_q != level_q) begin
      if (deb_q == DEB_LAST) begin
        level_d   = s2_q;
        press_now = level_q;
      end else begin
        deb_d = deb_q + DEB_ONE;
      end
    end

    count_d = count_q;
    wrap_d  = 1'b0;
    if (ENABLE) begin
      case (mode_e'(MODE))
        MODE_UP: if (tick_now) begin
          count_d = count_q + CNT_ONE;
          wrap_d  = (count_q == CNT_MAX);
        end
        MODE_DOWN: if (tick_now) begin
          count_d = count_q - CNT_ONE;
          wrap_d  = (count_q == CNT_ZERO);
        end
        MODE_KEY: if (press_now) begin
          count_d = count_q + CNT_ONE;
          wrap_d  = (count_q == CNT_MAX);
        end
        default: count_d = LOAD_VAL;
      endcase
    end

    hex_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_d[7*i +: 7] = seg7(count_q[4*i +: 4]);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      level_q <= 1'b1;
      deb_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      hex_q   <= HEX_RESET;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      deb_q   <= deb_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      hex_q   <= hex_d;
    end
  end

  assign COUNT = count_q;
  assign HEX   = hex_q;
  assign TICK  = tick_q;
  assign BLINK = blink_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_tick_counter_display.sv
// Scoreboard bench for tick_counter_display: per-edge expectations from a
// behavioural model are queued by the driver and popped by an output monitor.
module tb_tick_counter_display;

  localparam int DIV = 4;
  localparam int DEB = 3;
  localparam int ND  = 2;
  localparam int CW  = 4 * ND;
  localparam int HW  = 7 * ND;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          key_n;
  logic          en;
  logic [1:0]    mode;
  logic [CW-1:0] load;
  logic [CW-1:0] count;
  logic [HW-1:0] hex;
  logic          tick;
  logic          blink;
  logic          wrap;

  tick_counter_display #(
    .DIV(DIV), .DIV_WIDTH(4), .DEB_CYCLES(DEB), .DEB_WIDTH(4), .NUM_DIGITS(ND)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .KEY_N(key_n), .ENABLE(en), .MODE(mode),
    .LOAD_VAL(load), .COUNT(count), .HEX(hex), .TICK(tick), .BLINK(blink),
    .WRAP(wrap)
  );

  typedef struct {
    logic [CW-1:0] count;
    logic          tick;
    logic          blink;
    logic          wrap;
    logic [HW-1:0] hex;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Lit segments of each hex glyph.
  string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                        "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  // Reference model state
  int n;
  int m_count;
  bit m_level;
  int m_run;
  bit sync_q[$];

  function automatic logic [6:0] glyph_bits(input int d);
    string s;
    logic [6:0] b;
    s = glyph[d];
    b = 7'h7F;
    for (int i = 0; i < s.len(); i++) b[int'(s.getc(i)) - 97] = 1'b0;
    return b;
  endfunction

  function automatic logic [HW-1:0] expected_hex(input int c);
    logic [HW-1:0] h;
    h = '0;
    for (int d = 0; d < ND; d++) h[7*d +: 7] = glyph_bits((c >> (4*d)) & 15);
    return h;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one edge's inputs, predict the outputs after that edge, wait to the next negedge.
  task automatic step(input bit r, input bit e, input bit [1:0] md, input bit [CW-1:0] lv, input bit k);
    exp_t x;
    bit   s2;
    bit   press;
    rst = r; en = e; mode = md; load = lv; key_n = k;
    if (r) begin
      n = 0; m_count = 0; m_level = 1'b1; m_run = 0;
      sync_q = '{1'b1, 1'b1};
      x.count = '0; x.tick = 1'b0; x.blink = 1'b0; x.wrap = 1'b0;
      x.hex = expected_hex(0);
    end else begin
      n++;
      x.tick  = ((n % DIV) == 0);
      x.blink = (((n / DIV) % 2) == 1);
      s2 = sync_q.pop_front();
      sync_q.push_back(k);
      press = 1'b0;
      if (s2 != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          press   = (s2 == 1'b0);
          m_level = s2;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      x.hex  = expected_hex(m_count);
      x.wrap = 1'b0;
      if (e) begin
        case (md)
          2'd0: if (x.tick) begin x.wrap = (m_count == 255); m_count = (m_count + 1) % 256; end
          2'd1: if (x.tick) begin x.wrap = (m_count == 0);   m_count = (m_count + 255) % 256; end
          2'd2: if (press)  begin x.wrap = (m_count == 255); m_count = (m_count + 1) % 256; end
          default: m_count = int'(lv);
        endcase
      end
      x.count = CW'(m_count);
    end
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check("count", 32'(count), 32'(x.count));
        check("tick",  32'(tick),  32'(x.tick));
        check("blink", 32'(blink), 32'(x.blink));
        check("wrap",  32'(wrap),  32'(x.wrap));
        check("hex",   32'(hex),   32'(x.hex));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit r_rst, r_en, r_key;
    bit [1:0] r_mode;
    bit [CW-1:0] r_load;
    rst = 1'b1; en = 1'b0; mode = 2'd0; load = '0; key_n = 1'b1;
    @(negedge clk);

    // Free-running up count from reset
    step(1, 0, 2'd0, 8'h00, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 2'd0, 8'h00, 1);
    check("up5_count", 32'(count), 32'h05);
    check("up5_tick",  32'(tick),  32'h1);
    check("up5_blink", 32'(blink), 32'h1);
    step(0, 1, 2'd0, 8'h00, 1);
    check("hex_5", 32'(hex), 32'({7'b1000000, 7'b0010010}));

    // Load FE then count up through the wrap
    step(0, 1, 2'd3, 8'hFE, 1);
    for (int i = 0; i < 2; i++) step(0, 1, 2'd0, 8'h00, 1);
    check("up_ff_count", 32'(count), 32'hFF);
    step(0, 1, 2'd0, 8'h00, 1);
    check("hex_ff", 32'(hex), 32'({7'b0001110, 7'b0001110}));
    for (int i = 0; i < 3; i++) step(0, 1, 2'd0, 8'h00, 1);
    check("up_wrap_count", 32'(count), 32'h00);
    check("up_wrap_flag",  32'(wrap),  32'h1);
    step(0, 1, 2'd0, 8'h00, 1);
    check("hex_00", 32'(hex), 32'({7'b1000000, 7'b1000000}));
    check("wrap_pulse_end", 32'(wrap), 32'h0);

    // Down count through the wrap
    for (int i = 0; i < 3; i++) step(0, 1, 2'd1, 8'h00, 1);
    check("dn_wrap_count", 32'(count), 32'hFF);
    check("dn_wrap_flag",  32'(wrap),  32'h1);
    for (int i = 0; i < 4; i++) step(0, 1, 2'd1, 8'h00, 1);
    check("dn_fe_count", 32'(count), 32'hFE);
    check("dn_fe_wrap",  32'(wrap),  32'h0);

    // Bouncy key then a held press in key mode
    step(0, 1, 2'd2, 8'h00, 0);
    step(0, 1, 2'd2, 8'h00, 1);
    step(0, 1, 2'd2, 8'h00, 0);
    step(0, 1, 2'd2, 8'h00, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 2'd2, 8'h00, 0);
    check("key_before_accept", 32'(count), 32'hFE);
    step(0, 1, 2'd2, 8'h00, 0);
    check("key_accept", 32'(count), 32'hFF);
    for (int i = 0; i < 5; i++) step(0, 1, 2'd2, 8'h00, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 2'd2, 8'h00, 1);
    check("key_release", 32'(count), 32'hFF);

    // Enable low holds the count; a press in tick mode is ignored
    for (int i = 0; i < 14; i++) step(0, 0, 2'd0, 8'h00, 1);
    check("hold_count", 32'(count), 32'hFF);
    for (int i = 0; i < 8; i++) step(0, 1, 2'd0, 8'h00, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 2'd0, 8'h00, 1);

    // Reset with a pending debounce and a loaded count
    for (int i = 0; i < 3; i++) step(0, 1, 2'd3, 8'h37, 0);
    check("pre_reset_count", 32'(count), 32'h37);
    step(1, 1, 2'd3, 8'h37, 1);
    check("rst_count", 32'(count), 32'h00);
    check("rst_hex",   32'(hex),   32'({7'b1000000, 7'b1000000}));
    check("rst_tick",  32'(tick),  32'h0);
    check("rst_wrap",  32'(wrap),  32'h0);
    check("rst_blink", 32'(blink), 32'h0);
    for (int i = 0; i < 12; i++) step(0, 1, 2'd2, 8'h00, 1);
    check("no_press_after_rst", 32'(count), 32'h00);

    // Randomised traffic
    r_mode = 2'd0; r_key = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) r_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) r_key = ~r_key;
      r_en  = ($urandom_range(0, 7) != 0);
      r_rst = ($urandom_range(0, 249) == 0);
      case ($urandom_range(0, 4))
        0: r_load = 8'hFF;
        1: r_load = 8'h00;
        2: r_load = 8'hFE;
        3: r_load = 8'h01;
        default: r_load = 8'($urandom);
      endcase
      step(r_rst, r_en, r_mode, r_load, r_key);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
